// File: rtl/wb_regfile_pkg.sv
// Shared core constants: datapath/address widths, the PC register index and
// the writeback result-select encoding.
package wb_regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int PC_IDX = 15;

  typedef enum logic {
    RES_ALU = 1'b0,
    RES_MEM = 1'b1
  } resSel_e;

endpackage

// File: rtl/regfile_core.sv
// R0-R14 storage with two combinational read ports; R15 reads return PC+8.
// Writes land on the rising edge; reads bypass a same-cycle write, no stall.
module regfile_core
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = wb_regfile_pkg::DATA_W,
  parameter int ADDR_W = wb_regfile_pkg::ADDR_W
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              writeEn,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] readAddr1,
  input  logic [ADDR_W-1:0] readAddr2,
  input  logic [DATA_W-1:0] pcPlus8,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2
);

  localparam int                NUM_REGS = PC_IDX;
  localparam logic [ADDR_W-1:0] PC_ADDR  = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              storeEn;

  // R15 is the PC and lives in fetch, so a write to it never touches storage.
  assign storeEn = writeEn && (writeAddr != PC_ADDR);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (storeEn) begin
      regs[writeAddr] <= writeData;
    end
  end

  always_comb begin
    readData1 = '0;
    if (readAddr1 == PC_ADDR) begin
      readData1 = pcPlus8;
    end else if (writeEn && (writeAddr == readAddr1)) begin
      readData1 = writeData;
    end else begin
      readData1 = regs[readAddr1];
    end
  end

  always_comb begin
    readData2 = '0;
    if (readAddr2 == PC_ADDR) begin
      readData2 = pcPlus8;
    end else if (writeEn && (writeAddr == readAddr2)) begin
      readData2 = writeData;
    end else begin
      readData2 = regs[readAddr2];
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback result mux, PC redirect and retire counter around the register file.
// Results, redirect and reads are zero-latency; state updates on the edge, no backpressure.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = wb_regfile_pkg::DATA_W,
  parameter int ADDR_W = wb_regfile_pkg::ADDR_W
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              PCSrcW,
  input  logic              RegWriteW,
  input  logic              MemtoRegW,
  input  logic [DATA_W-1:0] ReadDataW,
  input  logic [DATA_W-1:0] ALUOutW,
  input  logic [ADDR_W-1:0] WA3W,
  input  logic [ADDR_W-1:0] RA1D,
  input  logic [ADDR_W-1:0] RA2D,
  input  logic [DATA_W-1:0] PCPlus8D,
  output logic [DATA_W-1:0] RD1D,
  output logic [DATA_W-1:0] RD2D,
  output logic [DATA_W-1:0] ResultW,
  output logic              PCRedirectW,
  output logic [DATA_W-1:0] PCTargetW,
  output logic [31:0]       RetireCnt
);

  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

  resSel_e resSel;
  logic    retireEn;
  logic [31:0] retireCnt;

  assign resSel  = resSel_e'(MemtoRegW);
  assign ResultW = (resSel == RES_MEM) ? ReadDataW : ALUOutW;

  // A register write aimed at R15 is a branch, same as an explicit PCSrcW.
  assign PCRedirectW = PCSrcW || (RegWriteW && (WA3W == PC_ADDR));
  assign PCTargetW   = PCRedirectW ? ResultW : '0;

  // One retirement per writeback slot even when both flags are set.
  assign retireEn = RegWriteW || PCSrcW;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      retireCnt <= '0;
    end else if (retireEn) begin
      retireCnt <= retireCnt + 32'd1;
    end
  end

  assign RetireCnt = retireCnt;

  regfile_core #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) uCore (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .writeEn  (RegWriteW),
    .writeAddr(WA3W),
    .writeData(ResultW),
    .readAddr1(RA1D),
    .readAddr2(RA2D),
    .pcPlus8  (PCPlus8D),
    .readData1(RD1D),
    .readData2(RD2D)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboarded bench for wb_regfile: stimulus pushes expected outputs, the
// negedge monitor pops and compares them.
module tb_wb_regfile;

  logic        CLK;
  logic        RESETn;
  logic        PCSrcW;
  logic        RegWriteW;
  logic        MemtoRegW;
  logic [31:0] ReadDataW;
  logic [31:0] ALUOutW;
  logic [3:0]  WA3W;
  logic [3:0]  RA1D;
  logic [3:0]  RA2D;
  logic [31:0] PCPlus8D;
  logic [31:0] RD1D;
  logic [31:0] RD2D;
  logic [31:0] ResultW;
  logic        PCRedirectW;
  logic [31:0] PCTargetW;
  logic [31:0] RetireCnt;

  wb_regfile dut (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .PCSrcW     (PCSrcW),
    .RegWriteW  (RegWriteW),
    .MemtoRegW  (MemtoRegW),
    .ReadDataW  (ReadDataW),
    .ALUOutW    (ALUOutW),
    .WA3W       (WA3W),
    .RA1D       (RA1D),
    .RA2D       (RA2D),
    .PCPlus8D   (PCPlus8D),
    .RD1D       (RD1D),
    .RD2D       (RD2D),
    .ResultW    (ResultW),
    .PCRedirectW(PCRedirectW),
    .PCTargetW  (PCTargetW),
    .RetireCnt  (RetireCnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] res;
    logic        redir;
    logic [31:0] tgt;
    logic [31:0] cnt;
  } exp_t;

  exp_t        expQ[$];
  exp_t        cur;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mReg[16];
  logic [31:0] mCnt;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) mReg[i] = '0;
    mCnt = '0;
  endtask

  // Drives one writeback/decode slot, queues the expected pre-edge outputs
  // and advances the model by the edge that follows.
  task automatic drive(input string tag, input logic pcs, input logic rw, input logic m2r,
                       input logic [31:0] rdat, input logic [31:0] alu, input logic [3:0] wa,
                       input logic [3:0] ra1, input logic [3:0] ra2, input logic [31:0] pc8);
    exp_t e;
    logic [31:0] res;
    PCSrcW = pcs; RegWriteW = rw; MemtoRegW = m2r; ReadDataW = rdat; ALUOutW = alu;
    WA3W = wa; RA1D = ra1; RA2D = ra2; PCPlus8D = pc8;
    res = m2r ? rdat : alu;
    e.tag   = tag;
    e.res   = res;
    e.rd1   = (ra1 == 4'd15) ? pc8 : ((rw && wa == ra1) ? res : mReg[ra1]);
    e.rd2   = (ra2 == 4'd15) ? pc8 : ((rw && wa == ra2) ? res : mReg[ra2]);
    e.redir = pcs || (rw && wa == 4'd15);
    e.tgt   = e.redir ? res : 32'd0;
    e.cnt   = mCnt;
    expQ.push_back(e);
    if (RESETn) begin
      if (rw && wa != 4'd15) mReg[wa] = res;
      if (rw || pcs) mCnt = mCnt + 32'd1;
    end
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (expQ.size() > 0) begin
      cur = expQ.pop_front();
      checkVal({cur.tag, ".RD1D"}, RD1D, cur.rd1);
      checkVal({cur.tag, ".RD2D"}, RD2D, cur.rd2);
      checkVal({cur.tag, ".ResultW"}, ResultW, cur.res);
      checkVal({cur.tag, ".PCRedirectW"}, {31'd0, PCRedirectW}, {31'd0, cur.redir});
      checkVal({cur.tag, ".PCTargetW"}, PCTargetW, cur.tgt);
      checkVal({cur.tag, ".RetireCnt"}, RetireCnt, cur.cnt);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESETn = 1'b0; PCSrcW = 0; RegWriteW = 0; MemtoRegW = 0; ReadDataW = '0; ALUOutW = '0;
    WA3W = '0; RA1D = '0; RA2D = '0; PCPlus8D = '0;
    modelReset();
    #2;
    checkVal("rst.RetireCnt", RetireCnt, 32'd0);
    checkVal("rst.RD1D", RD1D, 32'd0);
    @(posedge CLK);
    #1;

    // Writes are suppressed under reset but the bypass path still follows inputs.
    drive("rstWrite", 0, 1, 0, 32'h0, 32'h77, 4'd2, 4'd2, 4'd0, 32'h8);
    drive("rstPcw", 0, 1, 0, 32'h0, 32'h200, 4'd15, 4'd15, 4'd2, 32'h48);

    // Reset release coincides with a write to R5; it lands on this edge.
    RESETn = 1'b1;
    drive("wrR5", 0, 1, 0, 32'h0, 32'hDEADBEEF, 4'd5, 4'd2, 4'd5, 32'h8);
    drive("rdR5", 0, 0, 0, 32'h0, 32'h0, 4'd0, 4'd2, 4'd5, 32'h8);

    drive("bypassR7", 0, 1, 1, 32'hA5A5A5A5, 32'h1, 4'd7, 4'd7, 4'd7, 32'h8);
    drive("pcWrite", 0, 1, 0, 32'h0, 32'h100, 4'd15, 4'd15, 4'd7, 32'h48);
    drive("afterPc", 0, 0, 0, 32'h0, 32'h0, 4'd0, 4'd5, 4'd7, 32'h4C);
    drive("pcsAndWr", 1, 1, 0, 32'h0, 32'h4444, 4'd4, 4'd4, 4'd0, 32'h50);
    drive("pcsOnly", 1, 0, 1, 32'h3000, 32'h9, 4'd6, 4'd4, 4'd6, 32'h54);
    drive("sameReg", 0, 0, 0, 32'h0, 32'h0, 4'd0, 4'd4, 4'd4, 32'h58);

    for (int i = 0; i < 40; i++) begin
      drive("rand", ($urandom_range(0, 7) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom, $urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), $urandom);
    end

    for (int i = 0; i < 10; i++) begin
      drive("bubble", 0, 0, $urandom_range(0, 1), $urandom, $urandom, 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 32'h60);
    end

    // Mid-cycle asynchronous reset wipes R3 and the counter immediately.
    drive("wrR3", 0, 1, 0, 32'h0, 32'h1234, 4'd3, 4'd0, 4'd0, 32'h8);
    RegWriteW = 0; PCSrcW = 0; RA1D = 4'd3;
    #1;
    checkVal("preRst.RD1D", RD1D, mReg[3]);
    #2;
    RESETn = 1'b0;
    modelReset();
    #1;
    checkVal("midRst.RD1D", RD1D, mReg[3]);
    checkVal("midRst.RetireCnt", RetireCnt, mCnt);
    @(posedge CLK);
    #1;
    RESETn = 1'b1;
    drive("postRst", 0, 0, 0, 32'h0, 32'h0, 4'd0, 4'd3, 4'd5, 32'h8);

    // Counter wrap from all-ones.
    force dut.retireCnt = 32'hFFFFFFFF;
    #1;
    release dut.retireCnt;
    mCnt = 32'hFFFFFFFF;
    drive("wrapWrite", 0, 1, 0, 32'h0, 32'hCAFE, 4'd9, 4'd9, 4'd0, 32'h8);
    drive("wrapped", 0, 0, 0, 32'h0, 32'h0, 4'd0, 4'd9, 4'd0, 32'h8);

    @(posedge CLK);
    #1;
    checkVal("sbDrain", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
